// File: rtl/pool2x2_sched_pkg.sv
// Shared types, widths and thermometer helpers for the 2x2 pooling scheduler.
package pool_pkg;

    localparam int unsigned PIX_W   = 4;
    localparam int unsigned THERM_W = 15;

    typedef enum logic [1:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW,
        DRAIN
    } state_t;

    // Value v sets the low v bits.
    function automatic logic [THERM_W-1:0] to_therm(input logic [PIX_W-1:0] pix);
        logic [THERM_W-1:0] t;
        for (int i = 0; i < THERM_W; i++) begin
            t[i] = (i < int'(pix));
        end
        return t;
    endfunction

    // Population count of a thermometer code gives back the binary value.
    function automatic logic [PIX_W-1:0] therm_to_bin(input logic [THERM_W-1:0] t);
        logic [PIX_W-1:0] s;
        s = '0;
        for (int i = 0; i < THERM_W; i++) begin
            s = s + PIX_W'(t[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/pool2x2_sched_if.sv
// Pixel-in / pooled-pixel-out handshake bundle plus frame control and status.
interface pool2x2_sched_if;
    import pool_pkg::*;

    logic             start;
    logic             in_valid;
    logic [PIX_W-1:0] in_pix;
    logic             in_ready;
    logic             out_valid;
    logic [PIX_W-1:0] out_pix;
    logic             out_ready;
    logic             busy;
    logic             done;

    modport master (
        output start, in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_pix, busy, done
    );

    modport slave (
        input  start, in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_pix, busy, done
    );

endinterface

// File: rtl/thermo_maj.sv
// Four-input thermometer majority: output bit i is set when at least two inputs
// exceed i, which is the thermometer code of the second-largest input.
module thermo_maj
    import pool_pkg::*;
(
    input  logic [THERM_W-1:0] a,
    input  logic [THERM_W-1:0] b,
    input  logic [THERM_W-1:0] c,
    input  logic [THERM_W-1:0] d,
    output logic [THERM_W-1:0] maj
);

    assign maj = (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);

endmodule

// File: rtl/pool2x2_sched.sv
// Frame controller for 2x2 pooling: buffers the even row, assembles each window
// on the odd row and emits the second-largest pixel through a one-entry output.
module pool2x2_sched
    import pool_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pool2x2_sched_if.slave  bus
);

    localparam int unsigned CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d, col_prev;
    logic [RW-1:0]    row_q, row_d;
    logic [PIX_W-1:0] linebuf_q [IMG_W];
    logic [PIX_W-1:0] hold_q;
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_pix_q, out_pix_d;
    logic             done_q, done_d;

    logic             in_rdy, in_xfer, out_xfer;
    logic             lb_we, hold_we, win_load;
    logic [THERM_W-1:0] t_a, t_b, t_c, t_d, t_maj;

    // No skid: input stalls whenever a result is pending and not being taken.
    assign in_rdy   = ((state_q == EVEN_ROW) || (state_q == ODD_ROW)) &&
                      !(out_valid_q && !bus.out_ready);
    assign in_xfer  = bus.in_valid && in_rdy;
    assign out_xfer = out_valid_q && bus.out_ready;

    assign lb_we    = in_xfer && (state_q == EVEN_ROW);
    assign hold_we  = in_xfer && (state_q == ODD_ROW) && !col_q[0];
    assign win_load = in_xfer && (state_q == ODD_ROW) && col_q[0];
    assign col_prev = col_q - CW'(1);

    assign t_a = to_therm(linebuf_q[col_prev]);
    assign t_b = to_therm(linebuf_q[col_q]);
    assign t_c = to_therm(hold_q);
    assign t_d = to_therm(bus.in_pix);

    thermo_maj u_maj (
        .a   (t_a),
        .b   (t_b),
        .c   (t_c),
        .d   (t_d),
        .maj (t_maj)
    );

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pix   = out_pix_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

    // Row/column walk through the frame and completion detection.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = EVEN_ROW;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            EVEN_ROW: begin
                if (in_xfer) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        row_d   = row_q + RW'(1);
                        state_d = ODD_ROW;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            ODD_ROW: begin
                if (in_xfer) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d   = row_q + RW'(1);
                            state_d = EVEN_ROW;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!out_valid_q || out_xfer) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: a new window result wins over a same-cycle drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        if (win_load) begin
            out_valid_d = 1'b1;
            out_pix_d   = therm_to_bin(t_maj);
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            done_q      <= done_d;
        end
    end

    // Pixel storage needs no reset; it is always written before being read.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[col_q] <= bus.in_pix;
        end
        if (hold_we) begin
            hold_q <= bus.in_pix;
        end
    end

endmodule

// File: doc/pool2x2_sched.md
Name: pool2x2_sched

Overview:
- Frame-level controller for the 2x2 pooling filter.
- Accepts a raster stream of 4-bit pixels and buffers one even row in a line buffer.
- Assembles each 2x2 window, thermometer-encodes the four pixels and drives one thermo_maj instance.
- Emits the pooled pixel (second-largest of the window, ties counted individually) on a valid/ready output.
- Sits between the pixel source and the downstream pooled-image consumer.

Parameters:
- IMG_W, 8, pixels per row; even, >= 2.
- IMG_H, 8, rows per frame; even, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a frame; sampled only in IDLE.
- in_valid  input  1  in_pix valid.
- in_pix  input  4  binary pixel 0..15, raster order.
- in_ready  output  1  block accepts in_pix this cycle.
- out_valid  output  1  out_pix valid.
- out_pix  output  4  pooled pixel, binary.
- out_ready  input  1  downstream accepts out_pix.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; col, row and output counters = 0; in_ready=0, out_valid=0, out_pix=0, busy=0, done=0. Line buffer contents are don't-care.
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- IDLE: in_ready=0; start=1 -> EVEN_ROW with col=row=0.
- EVEN_ROW: each transfer writes linebuf[col]=in_pix and increments col. At col=IMG_W-1 the transfer sets col=0, increments row and goes to ODD_ROW.
- ODD_ROW, even col: the transfer stores in_pix in the hold register.
- ODD_ROW, odd col: the transfer forms window {linebuf[col-1], linebuf[col], hold, in_pix}. Each pixel is converted to 15-bit thermometer code (value v sets the low v bits) and fed to thermo_maj. The result is registered into out_pix and out_valid=1 on the next edge, giving 1-cycle latency from the completing input transfer.
- ODD_ROW end of row: at col=IMG_W-1, col=0 and row increments. If row was IMG_H-1 -> DRAIN, else -> EVEN_ROW.
- Backpressure: in_ready = (state is EVEN_ROW or ODD_ROW) && !(out_valid && !out_ready). This is a single-entry output register with no skid; out_pix must hold stable while out_valid && !out_ready.
- out_valid clears on an output transfer unless a new result loads in the same cycle. A simultaneous load and drain keeps out_valid=1 with the new data.
- DRAIN: in_ready=0. When out_valid=0, or an output transfer occurs, pulse done=1 for one cycle and go to IDLE.
- Output count per frame is (IMG_W/2)*(IMG_H/2), in raster order of windows.
- start outside IDLE is ignored.
- in_valid while in_ready=0 is ignored; no data is lost because the source must hold.
- rst_n asserted mid-frame: immediate return to reset values. A partially received frame is discarded and any pending out_pix is dropped.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H), minimum 1. Counters do not wrap mid-frame; they reset only at row or frame end.

Decomposition:
- Shared package pool_pkg holds:
  - PIX_W=4 and THERM_W=15.
  - Function to_therm(pix) returning 15-bit thermometer code.
  - Enum for states IDLE, EVEN_ROW, ODD_ROW, DRAIN.
- The one sub-module is the existing thermo_maj, instantiated once and purely combinational.
- The line buffer is an inline register array; no separate module.

Test Plan:
- IMG_W=2, IMG_H=2; start, then stream 1,2,4,3 -> one output out_pix=3; done pulses 1 cycle after the output transfer; busy falls with done.
- IMG_W=4, IMG_H=2; rows 9,2,15,14 / 0,13,0,14 -> outputs 9 then 14; ties case 15,14,0,14 gives 14.
- IMG_W=4, IMG_H=4, all pixels 15 then a frame of all pixels 0 -> four outputs of 15, then four outputs of 0. Windows 8,4,8,8 -> 8 and 2,6,2,8 -> 6.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending -> in_ready=0, out_pix stable, no input consumed; release -> stream resumes with no loss or duplication.
- Assert start mid-frame -> ignored and output count unchanged. Pull rst_n low mid ODD_ROW -> all outputs return to reset values immediately; the next frame after start pools correctly.
